// File: rtl/piso_tx_pkg.sv
// piso_tx_pkg: shared types and helpers for the serial word path.
//   state_e        - transmit FSM state {IDLE, SHIFT}
//   DEF_DATA_WID   - default word width
//   DEF_FIFO_DEPTH - default input buffer depth
//   idx_w()        - index width for counters/pointers (never below 1 bit)
package piso_tx_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    localparam int DEF_DATA_WID   = 8;
    localparam int DEF_FIFO_DEPTH = 4;

    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO, reusable on both ends of the serial path.
// Ports:
//   clk, rst_n          - clock, async active-low reset (empties the FIFO)
//   push_i, wdata_i     - write request/data; ignored while full
//   pop_i, rdata_o      - read request; rdata_o shows the head (show-ahead)
//   full_o, empty_o     - status from the registered count
//   count_o             - occupancy, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap by plain overflow.
module sync_fifo
    import piso_tx_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [idx_w(DEPTH):0]    count_o
);

    localparam int PW = idx_w(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [PW:0]      cnt_q;
    logic             do_push, do_pop;

    assign full_o  = (cnt_q == (PW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // A full FIFO refuses a push even when it pops in the same cycle.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Storage needs no reset: the count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/piso_tx.sv
// piso_tx: parallel-in/serial-out transmitter.
// Words enter on a valid/ready handshake into a FIFO, then leave one bit per
// clock; consecutive words stream with no idle gap.
// Ports:
//   clk, rst_n          - clock, async active-low reset (drops word in flight)
//   DataIn, in_valid    - parallel word and its valid
//   in_ready            - FIFO not full
//   SerOut, ser_valid   - serial bit and its qualifier (registered)
//   ser_first, ser_last - first / last bit of a word (registered)
//   busy                - FIFO non-empty or shifter active
module piso_tx
    import piso_tx_pkg::*;
#(
    parameter int DATA_WID   = DEF_DATA_WID,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [DATA_WID-1:0] DataIn,
    input  logic                in_valid,
    output logic                in_ready,
    output logic                SerOut,
    output logic                ser_valid,
    output logic                ser_first,
    output logic                ser_last,
    output logic                busy
);

    localparam int          CW   = idx_w(DATA_WID);
    localparam logic [CW-1:0] LAST = CW'(DATA_WID - 1);

    state_e                state_q, state_d;
    logic [DATA_WID-1:0]   sh_q, sh_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  pop;
    logic                  head_d;

    logic                  ser_out_q, ser_valid_q, ser_first_q, ser_last_q;

    logic [DATA_WID-1:0]   fifo_rdata;
    logic                  fifo_full, fifo_empty;
    logic [idx_w(FIFO_DEPTH):0] fifo_count;

    sync_fifo #(
        .WIDTH (DATA_WID),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (in_valid),
        .wdata_i (DataIn),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign in_ready = !fifo_full;
    assign busy     = (fifo_count != '0) || (state_q == SHIFT);

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    sh_d    = fifo_rdata;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_q == LAST) begin
                    cnt_d = '0;
                    // Reload on the last-bit edge so the next word follows
                    // with no idle cycle.
                    if (!fifo_empty) begin
                        pop  = 1'b1;
                        sh_d = fifo_rdata;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    sh_d  = MSB_FIRST ? {sh_q[DATA_WID-2:0], 1'b0}
                                      : {1'b0, sh_q[DATA_WID-1:1]};
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign head_d = MSB_FIRST ? sh_d[DATA_WID-1] : sh_d[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sh_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs are registered from next-state values so they line up with
    // the state/counter registers in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ser_out_q   <= 1'b0;
            ser_valid_q <= 1'b0;
            ser_first_q <= 1'b0;
            ser_last_q  <= 1'b0;
        end else begin
            ser_out_q   <= (state_d == SHIFT) && head_d;
            ser_valid_q <= (state_d == SHIFT);
            ser_first_q <= (state_d == SHIFT) && (cnt_d == '0);
            ser_last_q  <= (state_d == SHIFT) && (cnt_d == LAST);
        end
    end

    assign SerOut    = ser_out_q;
    assign ser_valid = ser_valid_q;
    assign ser_first = ser_first_q;
    assign ser_last  = ser_last_q;

endmodule

// File: tb/tb_piso_tx.sv
module tb_piso_tx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] DataIn = '0;
    logic       in_valid = 1'b0;

    logic rdy_m, so_m, sv_m, sf_m, sl_m, bz_m;
    logic rdy_l, so_l, sv_l, sf_l, sl_l, bz_l;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    piso_tx #(.DATA_WID(8), .FIFO_DEPTH(4), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst_n(rst_n), .DataIn(DataIn), .in_valid(in_valid),
        .in_ready(rdy_m), .SerOut(so_m), .ser_valid(sv_m),
        .ser_first(sf_m), .ser_last(sl_m), .busy(bz_m)
    );

    piso_tx #(.DATA_WID(8), .FIFO_DEPTH(4), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst_n(rst_n), .DataIn(DataIn), .in_valid(in_valid),
        .in_ready(rdy_l), .SerOut(so_l), .ser_valid(sv_l),
        .ser_first(sf_l), .ser_last(sl_l), .busy(bz_l)
    );

    // Reassemble words from the MSB-first stream.
    logic [7:0] acc_m = '0;
    logic [7:0] rx[$];
    always @(negedge clk) begin
        if (sv_m) begin
            if (sf_m) acc_m = '0;
            acc_m = {acc_m[6:0], so_m};
            if (sl_m) rx.push_back(acc_m);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Push one word; returns just after the accepting edge.
    task automatic push1(input logic [7:0] w);
        @(negedge clk);
        DataIn   = w;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    typedef struct {
        logic [7:0] din;
        bit         msb;
        logic [7:0] seq;   // expected bits in send order, seq[7] first
    } vec_t;

    vec_t vt[5];

    initial begin
        logic [15:0] bb;
        logic [7:0]  words[12];
        int          acc_at[6];
        int          nacc, w, c, hi, t;
        logic        rdy, ok;

        vt[0] = '{din: 8'hA5, msb: 1'b1, seq: 8'b10100101};
        vt[1] = '{din: 8'h3C, msb: 1'b1, seq: 8'b00111100};
        vt[2] = '{din: 8'h01, msb: 1'b0, seq: 8'b10000000};
        vt[3] = '{din: 8'h80, msb: 1'b0, seq: 8'b00000001};
        vt[4] = '{din: 8'hB4, msb: 1'b0, seq: 8'b00101101};

        // Reset state
        #12;
        chk("rst_SerOut",    so_m, 0);
        chk("rst_ser_valid", sv_m, 0);
        chk("rst_ser_first", sf_m, 0);
        chk("rst_ser_last",  sl_m, 0);
        chk("rst_busy",      bz_m, 0);
        chk("rst_in_ready",  rdy_m, 1);
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single words, both bit orders
        foreach (vt[i]) begin
            push1(vt[i].din);
            @(negedge clk);
            chk($sformatf("v%0d_wait_valid", i), vt[i].msb ? sv_m : sv_l, 0);
            chk($sformatf("v%0d_wait_busy", i),  vt[i].msb ? bz_m : bz_l, 1);
            for (int k = 0; k < 8; k++) begin
                @(negedge clk);
                chk($sformatf("v%0d_bit%0d", i, k),   vt[i].msb ? so_m : so_l, vt[i].seq[7-k]);
                chk($sformatf("v%0d_valid%0d", i, k), vt[i].msb ? sv_m : sv_l, 1);
                chk($sformatf("v%0d_first%0d", i, k), vt[i].msb ? sf_m : sf_l, (k == 0));
                chk($sformatf("v%0d_last%0d", i, k),  vt[i].msb ? sl_m : sl_l, (k == 7));
            end
            @(negedge clk);
            chk($sformatf("v%0d_after_valid", i), vt[i].msb ? sv_m : sv_l, 0);
            chk($sformatf("v%0d_after_busy", i),  vt[i].msb ? bz_m : bz_l, 0);
            repeat (2) @(negedge clk);
        end

        // Back-to-back words: 16 contiguous bits
        bb = 16'b0011110011000011;
        @(negedge clk);
        DataIn = 8'h3C; in_valid = 1'b1;
        @(posedge clk); #1 DataIn = 8'hC3;
        @(posedge clk); #1 in_valid = 1'b0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            chk($sformatf("bb_bit%0d", k),   so_m, bb[15-k]);
            chk($sformatf("bb_valid%0d", k), sv_m, 1);
            chk($sformatf("bb_first%0d", k), sf_m, (k == 0 || k == 8));
            chk($sformatf("bb_last%0d", k),  sl_m, (k == 7 || k == 15));
        end
        @(negedge clk);
        chk("bb_after_valid", sv_m, 0);
        repeat (2) @(negedge clk);

        // Back-pressure: hold in_valid with words 1..6
        rx.delete();
        w = 1; c = 0; nacc = 0;
        while (w <= 6 && c < 60) begin
            @(negedge clk);
            DataIn = 8'(w); in_valid = 1'b1; rdy = rdy_m;
            @(posedge clk);
            if (rdy) begin acc_at[nacc] = c; nacc++; w++; end
            c++;
        end
        #1 in_valid = 1'b0;
        chk("bp_accepted", nacc, 6);
        if (nacc == 6) begin
            chk("bp_acc0", acc_at[0], 0);
            chk("bp_acc4", acc_at[4], 4);
            chk("bp_acc5", acc_at[5], 10);
        end
        @(negedge clk);
        chk("bp_full_after_6", rdy_m, 0);
        t = 0;
        while (rx.size() < 6 && t < 200) begin @(negedge clk); t++; end
        chk("bp_rx_count", rx.size(), 6);
        for (int i = 0; i < 6 && i < rx.size(); i++)
            chk($sformatf("bp_rx%0d", i), rx[i], i + 1);
        repeat (3) @(negedge clk);

        // Reset during bit 3 of the first word
        @(negedge clk);
        DataIn = 8'hFF; in_valid = 1'b1;
        @(posedge clk); #1 DataIn = 8'h0F;
        @(posedge clk); #1 in_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("mr_bit3_valid", sv_m, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mr_SerOut",   so_m, 0);
        chk("mr_valid",    sv_m, 0);
        chk("mr_first",    sf_m, 0);
        chk("mr_last",     sl_m, 0);
        chk("mr_busy",     bz_m, 0);
        chk("mr_in_ready", rdy_m, 1);
        @(negedge clk) rst_n = 1'b1;
        hi = 0;
        repeat (20) begin
            @(negedge clk);
            if (sv_m || bz_m) hi++;
        end
        chk("mr_quiet_after", hi, 0);

        // Wrap-around: 12 random words with random gaps
        rx.delete();
        foreach (words[i]) words[i] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 12; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            ok = 1'b0; t = 0;
            while (!ok && t < 100) begin
                @(negedge clk);
                DataIn = words[i]; in_valid = 1'b1; ok = rdy_m;
                @(posedge clk);
                t++;
            end
            #1 in_valid = 1'b0;
            if (!ok) chk($sformatf("wr_push_timeout%0d", i), 0, 1);
        end
        t = 0;
        while (rx.size() < 12 && t < 300) begin @(negedge clk); t++; end
        chk("wr_rx_count", rx.size(), 12);
        for (int i = 0; i < 12 && i < rx.size(); i++)
            chk($sformatf("wr_rx%0d", i), rx[i], words[i]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
